// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution engine and its L1 readback path.
package conv_pkg;

  localparam int DATA_W  = 20;
  localparam int MAP_DIM = 32;
  localparam int IDX_W   = 10;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  index;
    logic              last;
  } fifo_entry_t;

endpackage

// File: rtl/conv_sync_fifo.sv
// Small synchronous FIFO with occupancy count; head is presented combinationally on dout.
module conv_sync_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign do_pop = pop && !empty;
  assign dout   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always @(posedge clk) begin
    if (reset_n) assert (!(push && full));
  end

endmodule

// File: rtl/conv_l1_reader.sv
// Reads the pooled feature map back from MEM_L1 and streams it row-major over valid/ready,
// using a credit-limited prefetch FIFO to absorb the memory latency and consumer stalls.
module conv_l1_reader
  import conv_pkg::*;
#(
  parameter int         DATA_W     = 20,
  parameter int         MAP_DIM    = 32,
  parameter int         ADDR_W     = 12,
  parameter int         FIFO_DEPTH = 2,
  parameter logic [2:0] CSEL_L1    = 3'b011
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [2:0]        csel,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [9:0]        out_index,
  output logic              out_last
);

  localparam int              TOTAL    = MAP_DIM * MAP_DIM;
  localparam int              CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  rd_state_e         state_q, state_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              crd_q, crd_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  fifo_entry_t       push_entry;
  fifo_entry_t       head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              credit_ok;

  // A read issued last cycle (crd_q) is the in-flight word; it lands in the FIFO this edge.
  assign push_entry.data  = cdata_rd;
  assign push_entry.index = caddr_q[IDX_W-1:0];
  assign push_entry.last  = (caddr_q[IDX_W-1:0] == LAST_IDX);

  conv_sync_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (crd_q),
    .din    (push_entry),
    .pop    (pop),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign pop = !fifo_empty && out_ready;

  // A same-cycle pop frees a slot, which is what sustains one word per cycle.
  assign credit_ok = !(fifo_full && !pop) &&
                     ((32'(fifo_count) + 32'(crd_q) + 32'd1) <= (32'(FIFO_DEPTH) + 32'(pop)));

  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    crd_d    = 1'b0;
    caddr_d  = caddr_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FETCH;
          rd_idx_d = '0;
        end
      end
      ST_FETCH: begin
        if (credit_ok) begin
          crd_d   = 1'b1;
          caddr_d = ADDR_W'(rd_idx_q);
          if (rd_idx_q == LAST_IDX) state_d = ST_DRAIN;
          else                      rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        // Words leave in order, so popping the last one implies FIFO empty and nothing in flight.
        if (pop && head.last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rd_idx_q <= '0;
      crd_q    <= 1'b0;
      caddr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      crd_q    <= crd_d;
      caddr_q  <= caddr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign crd       = crd_q;
  assign caddr_rd  = caddr_q;
  assign csel      = crd_q ? CSEL_L1 : 3'b000;

  // Head fields are forced to zero when empty so stale storage never reaches the consumer.
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head.data  : '0;
  assign out_index = out_valid ? head.index : '0;
  assign out_last  = out_valid ? head.last  : 1'b0;

endmodule

// File: tb/tb_conv_l1_reader.sv
// Directed bench for conv_l1_reader: reset, backpressure vector table, full-rate, random-ready and abort runs.
module tb_conv_l1_reader;

  localparam int DW    = 20;
  localparam int AW    = 12;
  localparam int DEPTH = 2;
  localparam int TOTAL = 1024;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [2:0]    csel;
  logic [DW-1:0] cdata_rd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [9:0]    out_index;
  logic          out_last;

  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int exp_k       = 0;
  int exp_addr    = 0;
  int popped      = 0;
  int last_hs_cyc = -10;
  int done_cnt    = 0;
  int done_cyc    = 0;

  conv_l1_reader #(
    .DATA_W(DW), .MAP_DIM(32), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .CSEL_L1(3'b011)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .csel     (csel),
    .cdata_rd (cdata_rd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last)
  );

  // Memory model: word at address a holds a*3; garbage when not read.
  assign cdata_rd = crd ? DW'(32'(caddr_rd) * 32'd3) : 20'h5A5A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stream monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_k       = 0;
      exp_addr    = 0;
      popped      = 0;
      last_hs_cyc = -10;
    end else begin
      chk("csel", 32'(csel), crd ? 32'd3 : 32'd0);
      chk("caddr_hi", 32'(caddr_rd[11:10]), 32'd0);
      if (crd) begin
        chk("read_addr", 32'(caddr_rd), 32'(exp_addr));
        exp_addr++;
        chk("credit_limit", 32'((exp_addr - popped) <= DEPTH), 32'd1);
      end
      if (out_valid && out_ready) begin
        chk("beat_data", 32'(out_data), 32'(exp_k * 3));
        chk("beat_index", 32'(out_index), 32'(exp_k));
        chk("beat_last", 32'(out_last), 32'(exp_k == TOTAL - 1));
        if (exp_k == TOTAL - 1) last_hs_cyc = cyc;
        exp_k++;
        popped++;
      end
      if (done) begin
        chk("done_after_last", 32'(cyc), 32'(last_hs_cyc + 1));
        chk("words_per_run", 32'(exp_k), 32'(TOTAL));
        done_cnt++;
        done_cyc = cyc;
        exp_k    = 0;
        exp_addr = 0;
        popped   = 0;
      end
    end
  end

  task automatic run_until_done(input bit rnd, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done_cnt != d0) break;
    end
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_busy;
    logic        exp_crd;
    logic [11:0] exp_caddr;
    logic        exp_valid;
    logic [19:0] exp_data;
    logic [9:0]  exp_index;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int s_cyc;
    bit pulsed;

    // start ready | busy crd caddr valid data index
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 20'd0, 10'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 1'b0, 20'd0, 10'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'd1, 1'b1, 20'd0, 10'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'd1, 1'b1, 20'd0, 10'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'd1, 1'b1, 20'd0, 10'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 12'd1, 1'b1, 20'd0, 10'd0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'd2, 1'b1, 20'd3, 10'd1};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'd3, 1'b1, 20'd6, 10'd2};

    void'($urandom(32'd20240607));
    reset_n   = 1'b0;
    start     = 1'b1;
    out_ready = 1'b0;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_crd", 32'(crd), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_csel", 32'(csel), 32'd0);
      chk("rst_caddr", 32'(caddr_rd), 32'd0);
    end
    reset_n = 1'b1;
    start   = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // Backpressure from the first word, then release.
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      start     = vecs[i].start;
      out_ready = vecs[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_crd", i), 32'(crd), 32'(vecs[i].exp_crd));
      chk($sformatf("vec%0d_caddr", i), 32'(caddr_rd), 32'(vecs[i].exp_caddr));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_index", i), 32'(out_index), 32'(vecs[i].exp_index));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'd0);
    end
    start = 1'b0;
    run_until_done(1'b0, 1200);
    chk("bp_run_done", 32'(done_cnt), 32'(d0 + 1));

    // Full-rate run with latency and throughput checks.
    @(posedge clk);
    #1;
    d0    = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    s_cyc = cyc;
    start = 1'b0;
    chk("fr_busy_s", 32'(busy), 32'd1);
    chk("fr_crd_s", 32'(crd), 32'd0);
    chk("fr_valid_s", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("fr_crd_s1", 32'(crd), 32'd1);
    chk("fr_caddr_s1", 32'(caddr_rd), 32'd0);
    chk("fr_valid_s1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("fr_valid_s2", 32'(out_valid), 32'd1);
    chk("fr_data_s2", 32'(out_data), 32'd0);
    run_until_done(1'b0, 1200);
    chk("fr_run_done", 32'(done_cnt), 32'(d0 + 1));
    chk("fr_done_cycle", 32'(done_cyc), 32'(s_cyc + 1026));
    chk("fr_busy_after", 32'(busy), 32'd0);
    chk("fr_done_after", 32'(done), 32'd0);

    // Random consumer readiness over a full run.
    d0    = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    run_until_done(1'b1, 6000);
    chk("rnd_run_done", 32'(done_cnt), 32'(d0 + 1));

    // Restart attempt mid-stream, then abort with reset.
    d0     = done_cnt;
    pulsed = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (exp_k >= 500 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (exp_k >= 700) break;
      @(posedge clk);
      #1;
    end
    chk("abort_reached_700", 32'(exp_k >= 700), 32'd1);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    reset_n = 1'b0;
    start   = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_crd", 32'(crd), 32'd0);
    chk("abort_csel", 32'(csel), 32'd0);
    chk("abort_caddr", 32'(caddr_rd), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_data", 32'(out_data), 32'd0);
    chk("abort_index", 32'(out_index), 32'd0);
    chk("abort_last", 32'(out_last), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_quiet_done", 32'(done_cnt), 32'(d0));
    chk("abort_quiet_valid", 32'(out_valid), 32'd0);
    chk("abort_quiet_busy", 32'(busy), 32'd0);

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_crd", 32'(crd), 32'd1);
    chk("restart_caddr", 32'(caddr_rd), 32'd0);
    run_until_done(1'b1, 6000);
    chk("restart_run_done", 32'(done_cnt), 32'(d0 + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
